// File: rtl/vga_text_pkg.sv
// Shared constants and the fetch token carried down the text render pipeline.
package vga_text_pkg;
    localparam int CHAR_W            = 8;
    localparam int CHAR_H            = 16;
    localparam int COLS              = 80;
    localparam int ROWS              = 25;
    localparam int CURSOR_FIRST_LINE = 14;

    typedef struct packed {
        logic       valid;
        logic [6:0] col;
        logic [4:0] row;
        logic [3:0] line;
        logic       blank;
    } token_t;
endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register with a reset value; carries the syncs and the fetch tokens.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];
endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel pipeline: cell address -> text RAM -> font ROM -> serial pixels,
// with a blinking underline cursor and syncs delayed to match the pixel latency.
module vga_text_render
    import vga_text_pkg::*;
#(
    parameter int   COLS         = vga_text_pkg::COLS,
    parameter int   ROWS         = vga_text_pkg::ROWS,
    parameter int   RAM_LAT      = 2,
    parameter int   FONT_LAT     = 1,
    parameter int   BLINK_FRAMES = 16,
    parameter logic SYNC_IDLE    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        de,
    input  logic        hs,
    input  logic        vs,
    output logic [10:0] text_adb,
    output logic        text_ceb,
    output logic        text_oce,
    input  logic [7:0]  text_dout,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    input  logic [6:0]  cursor_col,
    input  logic [4:0]  cursor_row,
    input  logic        cursor_en,
    output logic        pix,
    output logic        de_o,
    output logic        hs_o,
    output logic        vs_o
);
    localparam int              L          = RAM_LAT + FONT_LAT + 1;
    localparam int              XB         = $clog2(CHAR_W);
    localparam int              YB         = $clog2(CHAR_H);
    localparam int              FW         = $clog2(BLINK_FRAMES);
    localparam logic [6:0]      COLS_L     = 7'(COLS);
    localparam logic [4:0]      ROWS_L     = 5'(ROWS);
    localparam logic [3:0]      CUR_LINE   = 4'(CURSOR_FIRST_LINE);
    localparam logic [FW-1:0]   FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [10:0]   r_adb;
    logic [11:0]   r_font_addr;
    logic [7:0]    r_shift;
    logic          r_de_prev;
    logic          r_armed;
    logic          r_vs_prev;
    logic [FW-1:0] r_frame;
    logic          r_blink_on;

    logic [6:0]  w_col;
    logic [4:0]  w_row;
    logic [10:0] w_adb;
    logic        w_blank;
    logic        w_de_rise;
    logic        w_issue;
    logic        w_vs_act;
    token_t      w_tok_in;
    token_t      w_tok_ram;
    token_t      w_tok_load;
    logic [7:0]  w_glyph_base;
    logic        w_cursor_hit;
    logic [7:0]  w_glyph;
    logic [2:0]  w_sync_q;

    assign w_col     = x[9:XB];
    assign w_row     = y[YB+4:YB];
    assign w_adb     = {w_row, 6'b0} + {2'b0, w_row, 4'b0} + {4'b0, w_col};
    assign w_blank   = (|y[9:YB+5]) | (w_row >= ROWS_L) | (w_col >= COLS_L);
    // After reset, fetching waits for a fresh de rise so no partial line is drawn.
    assign w_de_rise = de & ~r_de_prev;
    assign w_issue   = de && (x[XB-1:0] == '0) && (r_armed || w_de_rise);
    assign w_vs_act  = (vs != SYNC_IDLE) && (r_vs_prev == SYNC_IDLE);

    always_comb begin
        w_tok_in       = '0;
        w_tok_in.valid = w_issue;
        w_tok_in.col   = w_col;
        w_tok_in.row   = w_row;
        w_tok_in.line  = y[YB-1:0];
        w_tok_in.blank = w_blank;
    end

    vga_delay_line #(.WIDTH($bits(token_t)), .DEPTH(RAM_LAT)) u_tok_ram (
        .i_clk(clk), .i_reset(reset), .i_d(w_tok_in), .o_q(w_tok_ram)
    );

    vga_delay_line #(.WIDTH($bits(token_t)), .DEPTH(FONT_LAT + 1)) u_tok_font (
        .i_clk(clk), .i_reset(reset), .i_d(w_tok_ram), .o_q(w_tok_load)
    );

    vga_delay_line #(.WIDTH(3), .DEPTH(L), .RST_VAL({1'b0, SYNC_IDLE, SYNC_IDLE})) u_sync (
        .i_clk(clk), .i_reset(reset), .i_d({de, hs, vs}), .o_q(w_sync_q)
    );

    assign w_glyph_base = w_tok_load.blank ? 8'h00 : font_data;
    assign w_cursor_hit = cursor_en && r_blink_on
                          && (w_tok_load.col == cursor_col)
                          && (w_tok_load.row == cursor_row)
                          && (w_tok_load.line >= CUR_LINE);
    assign w_glyph      = w_cursor_hit ? ~w_glyph_base : w_glyph_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_adb       <= '0;
            r_font_addr <= '0;
            r_shift     <= '0;
            r_de_prev   <= 1'b1;
            r_armed     <= 1'b0;
            r_vs_prev   <= SYNC_IDLE;
            r_frame     <= '0;
            r_blink_on  <= 1'b1;
        end else begin
            r_de_prev <= de;
            r_vs_prev <= vs;
            if (w_de_rise) r_armed <= 1'b1;
            // Blank cells keep the previous address so nothing past the screen is read.
            if (w_issue && !w_blank) r_adb <= w_adb;
            if (w_tok_ram.valid) r_font_addr <= {text_dout, w_tok_ram.line};
            r_shift <= w_tok_load.valid ? {w_glyph[6:0], 1'b0} : {r_shift[6:0], 1'b0};
            if (w_vs_act) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame    <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    assign text_adb  = r_adb;
    assign font_addr = r_font_addr;
    assign text_ceb  = ~reset;
    assign text_oce  = ~reset;
    assign de_o      = w_sync_q[2];
    assign hs_o      = w_sync_q[1];
    assign vs_o      = w_sync_q[0];
    assign pix       = de_o & (w_tok_load.valid ? w_glyph[7] : r_shift[7]);
endmodule

// File: tb/tb_vga_text_render.sv
// Directed bench for vga_text_render with behavioural text RAM and font ROM.
module tb_vga_text_render;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        de, hs, vs;
    logic [10:0] text_adb;
    logic        text_ceb, text_oce;
    logic [7:0]  text_dout;
    logic [11:0] font_addr;
    logic [7:0]  font_data;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        cursor_en;
    logic        pix, de_o, hs_o, vs_o;

    vga_text_render dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .de(de), .hs(hs), .vs(vs),
        .text_adb(text_adb), .text_ceb(text_ceb), .text_oce(text_oce), .text_dout(text_dout),
        .font_addr(font_addr), .font_data(font_data),
        .cursor_col(cursor_col), .cursor_row(cursor_row), .cursor_en(cursor_en),
        .pix(pix), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o)
    );

    always #5 clk = ~clk;

    // text_adb is the RAM address register, r_ram_q its output register: 2 clocks from x.
    logic [7:0] mem [0:2047];
    logic [7:0] rom [0:4095];
    logic [7:0] r_ram_q;
    always @(posedge clk) begin
        r_ram_q   <= mem[text_adb];
        font_data <= rom[font_addr];
    end
    assign text_dout = r_ram_q;

    localparam int NCAP = 4096;
    logic        cap_pix [NCAP];
    logic        cap_de  [NCAP];
    logic        cap_hs  [NCAP];
    logic        cap_vs  [NCAP];
    logic [10:0] cap_adb [NCAP];
    logic [11:0] cap_fa  [NCAP];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int c, c2, ones, mx;
    logic [7:0]  w;
    logic [15:0] pd, ph, pv, od, oh, ov;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (cyc < NCAP) begin
            cap_pix[cyc] = pix;
            cap_de[cyc]  = de_o;
            cap_hs[cyc]  = hs_o;
            cap_vs[cyc]  = vs_o;
            cap_adb[cyc] = text_adb;
            cap_fa[cyc]  = font_addr;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            de = 1'b0;
            tick();
        end
    endtask

    task automatic run_span(input int x0, input int yv, input int n, output int c0);
        c0 = cyc;
        for (int i = 0; i < n; i++) begin
            x  = 10'(x0 + i);
            y  = 10'(yv);
            de = 1'b1;
            tick();
        end
        de = 1'b0;
    endtask

    task automatic cell_word(input int c0, output logic [7:0] wd);
        for (int k = 0; k < 8; k++) wd[7-k] = cap_pix[c0 + 4 + k];
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b0;
            tick();
            vs = 1'b1;
            tick();
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
        for (int a = 0; a < 4096; a++) rom[a] = 8'h00;
        mem[0]    = 8'h41;
        mem[1]    = 8'h41;
        mem[81]   = 8'h42;
        mem[1999] = 8'h43;
        for (int a = 2000; a < 2048; a++) mem[a] = 8'hFF;
        rom[12'h410] = 8'h3C;
        rom[12'h420] = 8'hA5;
        rom[12'h43F] = 8'h81;
        for (int l = 0; l < 16; l++) rom[12'hFF0 + l] = 8'hFF;

        reset = 1'b1; x = '0; y = '0; de = 1'b0; hs = 1'b1; vs = 1'b1;
        cursor_col = '0; cursor_row = '0; cursor_en = 1'b0;
        repeat (3) tick();
        chk("rst_hs_o", hs_o, 1);
        chk("rst_vs_o", vs_o, 1);
        chk("rst_de_o", de_o, 0);
        chk("rst_pix", pix, 0);
        chk("rst_adb", text_adb, 0);
        chk("rst_font_addr", font_addr, 0);
        chk("rst_ceb", text_ceb, 0);
        chk("rst_oce", text_oce, 0);
        reset = 1'b0;
        tick();
        chk("run_ceb", text_ceb, 1);
        chk("run_oce", text_oce, 1);
        idle(4);

        // First cell 'A' line 0, second cell also 'A'.
        run_span(0, 0, 16, c);
        idle(6);
        chk("c0_adb", cap_adb[c+1], 0);
        chk("c0_font_addr", cap_fa[c+3], 12'h410);
        chk("c0_de_o_before", cap_de[c+3], 0);
        chk("c0_de_o_at_L", cap_de[c+4], 1);
        cell_word(c, w);
        chk("c0_pix", w, 8'h3C);
        cell_word(c + 8, w);
        chk("c1_pix", w, 8'h3C);
        chk("c0_de_o_after", cap_de[c+20], 0);

        run_span(0, 16, 16, c);
        idle(6);
        chk("row1_adb", cap_adb[c+1], 80);
        chk("r1c1_adb", cap_adb[c+9], 81);
        cell_word(c + 8, w);
        chk("r1c1_pix", w, 8'hA5);

        run_span(632, 399, 8, c);
        idle(6);
        chk("last_adb", cap_adb[c+1], 1999);
        chk("last_font_addr", cap_fa[c+3], 12'h43F);
        cell_word(c, w);
        chk("last_pix", w, 8'h81);

        // Rows 25 and beyond are blank and must not move the RAM address.
        c2 = cyc;
        for (int yy = 400; yy < 416; yy++) begin
            run_span(0, yy, 32, c);
            idle(4);
        end
        idle(4);
        ones = 0;
        mx = 0;
        for (int k = c2 + 1; k <= cyc; k++) begin
            if (cap_pix[k] === 1'b1) ones++;
            if (int'(cap_adb[k]) > mx) mx = int'(cap_adb[k]);
        end
        chk("blank_pix_ones", ones, 0);
        chk("blank_adb_max", mx, 1999);

        cursor_en = 1'b1;
        run_span(0, 14, 8, c);
        idle(6);
        cell_word(c, w);
        chk("cursor_on", w, 8'hFF);
        run_span(0, 13, 8, c);
        idle(6);
        cell_word(c, w);
        chk("cursor_line13", w, 8'h00);
        vs_pulses(15);
        run_span(0, 14, 8, c);
        idle(6);
        cell_word(c, w);
        chk("blink_15", w, 8'hFF);
        vs_pulses(1);
        run_span(0, 14, 8, c);
        idle(6);
        cell_word(c, w);
        chk("blink_16", w, 8'h00);
        vs_pulses(16);
        run_span(0, 14, 16, c);
        idle(6);
        cell_word(c, w);
        chk("blink_32", w, 8'hFF);
        cell_word(c + 8, w);
        chk("cursor_col1", w, 8'h00);
        run_span(0, 15, 8, c);
        idle(6);
        cell_word(c, w);
        chk("cursor_line15", w, 8'hFF);
        cursor_en = 1'b0;

        pd = 16'b0011_0110_1110_0101;
        ph = 16'b1110_0111_1011_0001;
        pv = 16'b1111_1011_0111_1110;
        c = cyc;
        for (int k = 0; k < 16; k++) begin
            x = 10'd1; de = pd[k]; hs = ph[k]; vs = pv[k];
            tick();
        end
        de = 1'b0; hs = 1'b1; vs = 1'b1;
        idle(6);
        for (int k = 0; k < 16; k++) begin
            od[k] = cap_de[c+4+k];
            oh[k] = cap_hs[c+4+k];
            ov[k] = cap_vs[c+4+k];
        end
        chk("delay_de", od, pd);
        chk("delay_hs", oh, ph);
        chk("delay_vs", ov, pv);

        // Reset lands at x=3 of a cell already in flight, held for two clocks.
        c = cyc;
        hs = 1'b0; vs = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x = 10'(k); y = 10'd0; de = 1'b1;
            tick();
        end
        x = 10'd3; reset = 1'b1;
        tick();
        x = 10'd4;
        tick();
        chk("midrst_pix", cap_pix[c+4] | cap_pix[c+5], 0);
        chk("midrst_de_o", cap_de[c+4] | cap_de[c+5], 0);
        chk("midrst_hs_o", cap_hs[c+4] & cap_hs[c+5], 1);
        chk("midrst_vs_o", cap_vs[c+4] & cap_vs[c+5], 1);
        reset = 1'b0; hs = 1'b1; vs = 1'b1;
        for (int k = 5; k < 32; k++) begin
            x = 10'(k);
            tick();
        end
        de = 1'b0;
        idle(6);
        run_span(0, 0, 16, c2);
        idle(6);
        ones = 0;
        for (int k = c + 4; k <= c2 + 3; k++) if (cap_pix[k] !== 1'b0) ones++;
        chk("postrst_quiet", ones, 0);
        cell_word(c2, w);
        chk("postrst_glyph", w, 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Downstream consumer of the 2K x 8 text RAM: converts timing-generator pixel coordinates into text-RAM read addresses, then font-ROM addresses, then a serial monochrome pixel stream.
- Fixed mode: 80x25 cells, 8x16 glyphs, 640x400 active area.
- Overlays a blinking underline cursor and delays de/hsync/vsync so they stay pixel-aligned with the pixel output.
- Sits between vga_timing and the DAC/output pins; drives text RAM port B and the font ROM.

Parameters:
- COLS, 80, characters per row; also the row stride in the text RAM.
- ROWS, 25, character rows; cells with row >= ROWS display blank.
- RAM_LAT, 2, text RAM read latency in clocks (pipelined read mode with oce).
- FONT_LAT, 1, font ROM read latency in clocks.
- BLINK_FRAMES, 16, vsync pulses per cursor blink half-period.
- SYNC_IDLE, 1'b1, level of hs_o/vs_o during reset (inactive level).

Ports:
- clk  in  1  pixel clock, also text RAM clkb.
- reset  in  1  synchronous, active-high.
- x  in  10  pixel column from timing generator, valid when de=1.
- y  in  10  pixel line from timing generator.
- de  in  1  display enable.
- hs  in  1  horizontal sync.
- vs  in  1  vertical sync, active level = !SYNC_IDLE.
- text_adb  out  11  text RAM read address.
- text_ceb  out  1  text RAM read clock enable.
- text_oce  out  1  text RAM output register enable.
- text_dout  in  8  character code returned RAM_LAT clocks after the address.
- font_addr  out  12  {char[7:0], glyph_line[3:0]}.
- font_data  in  8  glyph row, MSB = leftmost pixel, FONT_LAT clocks after font_addr.
- cursor_col  in  7  cursor column.
- cursor_row  in  5  cursor row.
- cursor_en  in  1  cursor visible.
- pix  out  1  pixel output, 1 = foreground.
- de_o  out  1  de delayed by L.
- hs_o  out  1  hs delayed by L.
- vs_o  out  1  vs delayed by L.

Behaviour:
- Reset (synchronous, active-high):
  - text_adb=0, font_addr=0, pix=0, de_o=0.
  - hs_o=vs_o=SYNC_IDLE.
  - Shift register, delay lines, frame counter and blink state cleared.
  - text_ceb=0, text_oce=0.
  - Reset asserted mid-line or mid-frame takes effect the next clock; output resumes cleanly at the next de rising edge after release.
- Outside reset: text_ceb=text_oce=1.
- Address stage (stage 0): when de=1 and x[2:0]==0:
  - col=x[9:3], row=y[8:4].
  - text_adb <= row*80+col, computed as (row<<6)+(row<<4)+col, 11 bits.
  - A valid token is issued with col, row, y[3:0], and blank=(row>=ROWS or col>=COLS).
- Token pipeline: the token travels RAM_LAT clocks alongside the read. Then:
  - font_addr <= {text_dout, line}.
  - Token continues FONT_LAT clocks.
- Load stage:
  - glyph = font_data, forced to 0 if blank.
  - If cursor_en, token col==cursor_col, row==cursor_row, line>=14 and blink_on: glyph = ~glyph restricted to lines 14-15 (underline, XOR).
  - Shift register loaded with glyph.
  - pix = glyph[7] in the same clock; shift left on each following clock.
- Latency: L = RAM_LAT+FONT_LAT+1 clocks (4 at defaults) from x/de input to pix/de_o.
  - de, hs, vs use a shift delay of exactly L.
  - pix forced 0 whenever de_o=0.
- Throughput: one fetch every 8 clocks; pipeline depth < 8, so tokens never collide. x[2:0]!=0 never issues a token.
- Blink: frame counter increments on each vs active edge (detected on the undelayed vs). At BLINK_FRAMES-1 it wraps to 0 and toggles blink_on. blink_on reset value = 1.
- Partial last cell when de falls with x[2:0]!=0: the remaining shift content is masked by de_o.

Decomposition:
- Shared package vga_text_pkg holds:
  - constants CHAR_W=8, CHAR_H=16, COLS, ROWS, CURSOR_FIRST_LINE=14;
  - the token struct typedef {valid, col, row, line, blank}.
- One natural sub-module: vga_delay_line (parameterised width/depth shift register with reset value), used for sync delay and the token pipeline.

Test Plan:
- Behavioural RAM and ROM models. Char at addr 0 = 0x41, glyph(0x41, line 0) = 8'b0011_1100; drive x=0..7, y=0, de=1 -> text_adb=0 at cycle 1, font_addr=0x410, pix sequence 0,0,1,1,1,1,0,0 starting L=4 clocks after x=0.
- x=8, y=16 -> text_adb=81. Then x=632, y=399 -> text_adb=1999, font_addr line field=15.
- y=400..415 with de=1 -> pix all 0; no out-of-range address >1999 issued.
- Cursor at (col 0, row 0), cursor_en=1, glyph line 14 = 0x00 -> pix=8 ones on line 14. After 16 vs pulses -> 8 zeros. After 32 pulses -> ones again.
- Delay alignment: toggle de/hs/vs with known patterns -> de_o/hs_o/vs_o equal the inputs shifted exactly 4 clocks. During reset, hs_o=vs_o=1 and pix=de_o=0.
- Assert reset at x=3 mid-cell, release 2 clocks later -> pix=0 until the next de rising edge, then a correct glyph at latency 4.
